vec_alu_engine: RTL
===================

Name: vec_alu_engine

Overview:
- Parametrised multi-lane successor to the single-lane processor datapath.
- Streams a contiguous range of operand groups from the A, B and op memories, applies a per-lane ALU op, and writes results to the result memory.
- Sits between the host memory loaders and the result BRAM.
- Adds over the previous generation: configurable lanes and widths, programmable base and length, hold/backpressure, an illegal-op error flag, and pipelined one-group-per-cycle throughput.

Parameters:
- DATA_WIDTH, 32, bits per lane element.
- ADDR_WIDTH, 10, group address width for all memories.
- LANES, 1, elements per group (legal values 1, 2, 4, 8).
- OP_WIDTH, 4, opcode bits per lane.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- start_i  in  1  run request, sampled in IDLE only.
- base_addr_i  in  ADDR_WIDTH  first group address, captured at start.
- len_i  in  ADDR_WIDTH+1  number of groups, captured at start.
- hold_i  in  1  freezes the whole pipeline.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky illegal-opcode flag.
- rd_en_o  out  1  read enable to the A, B and op memories.
- rd_addr_o  out  ADDR_WIDTH  read group address.
- a_rdata_i  in  LANES*DATA_WIDTH  A data; 1-cycle latency, held while rd_en_o=0.
- b_rdata_i  in  LANES*DATA_WIDTH  B data, same timing as A.
- op_rdata_i  in  LANES*OP_WIDTH  op data, same timing as A.
- wr_en_o  out  1  result memory write enable.
- wr_addr_o  out  ADDR_WIDTH  result group address.
- wr_data_o  out  LANES*DATA_WIDTH  result data.

Behaviour:
- Reset (RST=0, asynchronous):
  - All outputs 0, FSM to IDLE, pipeline valids cleared, err_o cleared.
  - Reset mid-run aborts with no further writes.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start_i=1 at edge T captures base and length, clears err_o, and moves to RUN (or to DONE if len_i=0). start_i in any other state is ignored.
- RUN: each non-held cycle drives rd_en_o=1 with rd_addr_o = base+i, i = 0..L-1. Address arithmetic is modulo 2^ADDR_WIDTH (wraps from 1023 to 0). After the issue for i=L-1, the FSM moves to DRAIN.
- DRAIN: waits until both pipeline valids are clear, then moves to DONE.
- DONE: done_o=1 for one cycle, then returns to IDLE.
- Pipeline:
  - Stage 1 (issue) produces valid v1.
  - Stage 2: rdata arrives, lanes compute combinationally, and the result is registered together with wr_addr (= issue address) into v2.
  - wr_en_o = v2 & ~hold_i.
  - Issue-to-write latency is 2 cycles. Throughput is 1 group/cycle.
- Timing with no hold, start at edge T:
  - issues at T+1..T+L;
  - writes at T+3..T+L+2;
  - done_o at T+L+3;
  - busy_o high T+1..T+L+2.
- len_i=0: busy_o stays 0, done_o at T+1, no memory accesses.
- hold_i=1:
  - rd_en_o=0 and wr_en_o=0;
  - no counter, valid or FSM advance; pending data and results are retained;
  - this relies on the memories holding rdata while rd_en_o=0.
  - Hold in IDLE does not block acceptance of start_i.
- Lane op codes (lane k uses op bits [k*OP_WIDTH +: OP_WIDTH]):
  - 0 ADD, 1 SUB (wrap modulo 2^DATA_WIDTH).
  - 2 AND, 3 OR.
  - 4 SLL, 5 SRL; shift amount = low log2(DATA_WIDTH) bits of b.
  - 6 SLT: signed compare, result 1 or 0, zero-extended.
  - 7 XOR.
- Illegal opcode: lane result 0, err_o set at the write cycle, sticky until the next accepted start. Lanes are independent.

Optional Feature:
- Macro VALU_EXT_OPS_EN.
- When defined, enables three extra opcodes:
  - 8 SRA (arithmetic shift right);
  - 9 SLTU (unsigned compare);
  - 10 MUL (low DATA_WIDTH bits of the product, still combinational within stage 2).
- Codes 11–15 remain illegal.
- When undefined, codes 8–15 are illegal: result 0, err_o set.

Decomposition:
- Package valu_pkg holds the opcode constants, FSM state encoding and the op legality function.
- One sub-module, valu_lane: a combinational single-lane ALU (a, b, op → result, illegal). It is instantiated LANES times via a generate loop.

Test Plan:
- LANES=1, A=1, B=2, ops ADD/SUB/AND/OR/SLL/SRL/SLT/XOR across 8 groups → results 3, FFFFFFFF, 0, 3, 4, 0, 1, 3; done_o at T+11.
- LANES=4, base=1022, len=4 → writes to 1022, 1023, 0, 1; lane-distinct ops produce independent results.
- len=0 start → done_o at T+1, no rd_en_o or wr_en_o, busy_o stays 0.
- Hold for 5 cycles mid-run (L=16) → no writes during hold, all 16 results correct, done_o delayed by exactly 5 cycles.
- Op 12 in lane 0 → result 0 and err_o=1 after the write; next start clears err_o. With VALU_EXT_OPS_EN, op 8 on A=80000000, B=4 gives F8000000.
- RST dropped at write 3 of 8 → outputs 0 immediately, no further writes; a new start runs cleanly.

Source files
------------

// File: rtl/valu_pkg.sv
// Shared opcode constants, FSM encoding and opcode legality for vec_alu_engine.
// VALU_EXT_OPS_EN widens the legal opcode set to include SRA, SLTU and MUL.
package valu_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam int unsigned OpAdd  = 0;
    localparam int unsigned OpSub  = 1;
    localparam int unsigned OpAnd  = 2;
    localparam int unsigned OpOr   = 3;
    localparam int unsigned OpSll  = 4;
    localparam int unsigned OpSrl  = 5;
    localparam int unsigned OpSlt  = 6;
    localparam int unsigned OpXor  = 7;
    localparam int unsigned OpSra  = 8;
    localparam int unsigned OpSltu = 9;
    localparam int unsigned OpMul  = 10;

    function automatic logic op_legal(input logic [31:0] op);
`ifdef VALU_EXT_OPS_EN
        return op <= 32'(OpMul);
`else
        return op <= 32'(OpXor);
`endif
    endfunction

endpackage

// File: rtl/valu_lane.sv
// Combinational single-lane ALU; illegal opcodes yield a zero result.
// Extra opcodes are compiled in when VALU_EXT_OPS_EN is defined.
module valu_lane
    import valu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 4
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [OP_WIDTH-1:0]   op,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  illegal
);

    localparam int unsigned ShW = $clog2(DATA_WIDTH);

    logic [ShW-1:0] shamt;
    logic [31:0]    op_ext;

    assign shamt  = b[ShW-1:0];
    assign op_ext = 32'(op);

    always_comb begin
        result  = '0;
        illegal = !op_legal(op_ext);
        case (op_ext)
            OpAdd:  result = a + b;
            OpSub:  result = a - b;
            OpAnd:  result = a & b;
            OpOr:   result = a | b;
            OpSll:  result = a << shamt;
            OpSrl:  result = a >> shamt;
            OpSlt:  result = DATA_WIDTH'($signed(a) < $signed(b));
            OpXor:  result = a ^ b;
`ifdef VALU_EXT_OPS_EN
            OpSra:  result = DATA_WIDTH'($signed(a) >>> shamt);
            OpSltu: result = DATA_WIDTH'(a < b);
            OpMul:  result = a * b;
`endif
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/vec_alu_engine.sv
// Streams operand groups through LANES parallel ALUs into the result memory,
// one group per cycle, two-stage pipeline with global hold. Optional: VALU_EXT_OPS_EN.
module vec_alu_engine
    import valu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LANES      = 1,
    parameter int unsigned OP_WIDTH   = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        start_i,
    input  logic [ADDR_WIDTH-1:0]       base_addr_i,
    input  logic [ADDR_WIDTH:0]         len_i,
    input  logic                        hold_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic                        rd_en_o,
    output logic [ADDR_WIDTH-1:0]       rd_addr_o,
    input  logic [LANES*DATA_WIDTH-1:0] a_rdata_i,
    input  logic [LANES*DATA_WIDTH-1:0] b_rdata_i,
    input  logic [LANES*OP_WIDTH-1:0]   op_rdata_i,
    output logic                        wr_en_o,
    output logic [ADDR_WIDTH-1:0]       wr_addr_o,
    output logic [LANES*DATA_WIDTH-1:0] wr_data_o
);

    localparam int unsigned GroupW = LANES * DATA_WIDTH;
    localparam int unsigned LenW   = ADDR_WIDTH + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LenW-1:0]       rem_q, rem_d;
    logic                  v1_q, v1_d;
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
    logic                  v2_q, v2_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [GroupW-1:0]     res_q, res_d;
    logic                  ill_q, ill_d;
    logic                  err_q, err_d;

    logic [GroupW-1:0]     lane_res;
    logic [LANES-1:0]      lane_ill;
    logic                  issue;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        valu_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .OP_WIDTH   (OP_WIDTH)
        ) u_lane (
            .a       (a_rdata_i[k*DATA_WIDTH +: DATA_WIDTH]),
            .b       (b_rdata_i[k*DATA_WIDTH +: DATA_WIDTH]),
            .op      (op_rdata_i[k*OP_WIDTH +: OP_WIDTH]),
            .result  (lane_res[k*DATA_WIDTH +: DATA_WIDTH]),
            .illegal (lane_ill[k])
        );
    end

    assign issue     = (state_q == StRun) && !hold_i;
    assign rd_en_o   = issue;
    assign rd_addr_o = addr_q;
    assign wr_en_o   = v2_q && !hold_i;
    assign wr_addr_o = waddr_q;
    assign wr_data_o = res_q;
    assign busy_o    = (state_q == StRun) || (state_q == StDrain);
    assign done_o    = (state_q == StDone);
    assign err_o     = err_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        v1_d    = v1_q;
        addr1_d = addr1_q;
        v2_d    = v2_q;
        waddr_d = waddr_q;
        res_d   = res_q;
        ill_d   = ill_q;
        err_d   = err_q;

        if (wr_en_o && ill_q) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    addr_d  = base_addr_i;
                    rem_d   = len_i;
                    err_d   = 1'b0;
                    state_d = (len_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (!hold_i) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - LenW'(1);
                    if (rem_q == LenW'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // With v1 empty and no hold, the final write retires this cycle.
                if (!hold_i && !v1_q) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (!hold_i) begin
            v1_d    = issue;
            addr1_d = addr_q;
            v2_d    = v1_q;
            if (v1_q) begin
                res_d   = lane_res;
                ill_d   = |lane_ill;
                waddr_d = addr1_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            v1_q    <= 1'b0;
            addr1_q <= '0;
            v2_q    <= 1'b0;
            waddr_q <= '0;
            res_q   <= '0;
            ill_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            v1_q    <= v1_d;
            addr1_q <= addr1_d;
            v2_q    <= v2_d;
            waddr_q <= waddr_d;
            res_q   <= res_d;
            ill_q   <= ill_d;
            err_q   <= err_d;
        end
    end

endmodule
